// File: rtl/string_fifo_pkg.sv
// Shared constants for the Avalon-MM string FIFO: register map addresses,
// STATUS / CONTROL bit positions and a helper that packs the STATUS word.
package string_fifo_pkg;

   // Register word addresses
   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_STATUS  = 3'd1;
   localparam logic [2:0] ADDR_COUNT   = 3'd2;
   localparam logic [2:0] ADDR_CONTROL = 3'd3;
   localparam logic [2:0] ADDR_THRESH  = 3'd4;

   // STATUS bit indices
   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_OVF   = 2;
   localparam int ST_UNF   = 3;
   localparam int ST_IRQ   = 4;
   localparam int ST_W     = 5;

   // CONTROL bit indices
   localparam int CTRL_FLUSH  = 0;
   localparam int CTRL_IRQ_EN = 1;

   // Pack the live STATUS flags into their bit positions
   function automatic logic [ST_W-1:0] status_word(
      input logic irq,
      input logic unf,
      input logic ovf,
      input logic full,
      input logic empty
   );
      logic [ST_W-1:0] w_s;
      w_s              = {ST_W{1'b0}};
      w_s[ST_EMPTY]    = empty;
      w_s[ST_FULL]     = full;
      w_s[ST_OVF]      = ovf;
      w_s[ST_UNF]      = unf;
      w_s[ST_IRQ]      = irq;
      return w_s;
   endfunction

endpackage

// File: rtl/sfifo_core.sv
// FIFO storage and pointer bookkeeping. Pointers carry one extra wrap bit so
// that full and empty are distinguishable without a separate counter.
module sfifo_core #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [DATA_W-1:0]        i_wdata,
   output logic [DATA_W-1:0]        o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic              w_do_push;
   logic              w_do_pop;

   // Push/pop are qualified here too so the core never corrupts itself
   assign w_do_push = i_push && !o_full && !i_flush;
   assign w_do_pop  = i_pop && !o_empty && !i_flush;

   // Pointer update: flush returns both pointers to zero, contents untouched
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
      end else if (i_flush) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
         end
      end
   end

   // Storage array: written on accepted pushes only, never reset
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
      end
   end

   assign o_count = r_wr_ptr - r_rd_ptr;
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/string_fifo_avalon_param.sv
// Avalon-MM slave wrapper around sfifo_core: register decode, sticky error
// flags, interrupt enable / threshold registers and the level interrupt.
module string_fifo_avalon_param
   import string_fifo_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              chipselect,
   input  logic [2:0]        address,
   input  logic              read,
   input  logic              write,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   output logic              irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic              r_armed;
   logic              r_ovf;
   logic              r_unf;
   logic              r_irq_en;
   logic [PW-1:0]     r_thresh;
   logic              r_irq;

   logic              w_wr_acc;
   logic              w_rd_acc;
   logic              w_push;
   logic              w_pop;
   logic              w_flush;
   logic              w_ovf_set;
   logic              w_unf_set;
   logic              w_ovf_clr;
   logic              w_unf_clr;
   logic              w_ctrl_wr;
   logic              w_thresh_wr;
   logic              w_irq_cond;
   logic [DATA_W-1:0] w_head;
   logic [PW-1:0]     w_count;
   logic              w_full;
   logic              w_empty;
   logic [DATA_W-1:0] w_rdata;

   // Decode the single Avalon access of this cycle into FIFO/register actions.
   // A write wins over a simultaneous read; nothing updates until armed.
   always_comb begin
      w_wr_acc    = 1'b0;
      w_rd_acc    = 1'b0;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_flush     = 1'b0;
      w_ovf_set   = 1'b0;
      w_unf_set   = 1'b0;
      w_ovf_clr   = 1'b0;
      w_unf_clr   = 1'b0;
      w_ctrl_wr   = 1'b0;
      w_thresh_wr = 1'b0;
      if (r_armed && chipselect) begin
         w_wr_acc = write;
         w_rd_acc = read && !write;
      end else begin
         w_wr_acc = 1'b0;
         w_rd_acc = 1'b0;
      end
      if (w_wr_acc) begin
         case (address)
            ADDR_DATA: begin
               w_push    = !w_full;
               w_ovf_set = w_full;
            end
            ADDR_STATUS: begin
               w_ovf_clr = writedata[ST_OVF];
               w_unf_clr = writedata[ST_UNF];
            end
            ADDR_CONTROL: begin
               w_ctrl_wr = 1'b1;
               w_flush   = writedata[CTRL_FLUSH];
            end
            ADDR_THRESH: begin
               w_thresh_wr = 1'b1;
            end
            default: begin
               w_push = 1'b0;
            end
         endcase
      end else if (w_rd_acc && (address == ADDR_DATA)) begin
         w_pop     = !w_empty;
         w_unf_set = w_empty;
      end else begin
         w_push = 1'b0;
      end
   end

   sfifo_core #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_wdata (writedata),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Arming flag: the first edge after reset release performs no update
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_armed <= 1'b0;
      end else begin
         r_armed <= 1'b1;
      end
   end

   // Sticky overflow/underflow flags: set by the faulting access, cleared by W1C
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
         end
         if (w_unf_set) begin
            r_unf <= 1'b1;
         end else if (w_unf_clr) begin
            r_unf <= 1'b0;
         end
      end
   end

   // CONTROL irq enable and THRESH registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq_en <= 1'b0;
         r_thresh <= PW'(DEPTH / 2);
      end else begin
         if (w_ctrl_wr) begin
            r_irq_en <= writedata[CTRL_IRQ_EN];
         end
         if (w_thresh_wr) begin
            r_thresh <= writedata[PW-1:0];
         end
      end
   end

   assign w_irq_cond = r_irq_en && ((w_count >= r_thresh) || r_ovf || r_unf);

   // Interrupt register: follows the enabled condition one cycle later
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= w_irq_cond;
      end
   end

   assign irq = r_irq;

   // Read mux: zero-wait data from address and current state, zero when idle
   always_comb begin
      w_rdata = {DATA_W{1'b0}};
      if (chipselect && read) begin
         case (address)
            ADDR_DATA: begin
               if (w_empty) begin
                  w_rdata = {DATA_W{1'b0}};
               end else begin
                  w_rdata = w_head;
               end
            end
            ADDR_STATUS:  w_rdata = DATA_W'(status_word(r_irq, r_unf, r_ovf, w_full, w_empty));
            ADDR_COUNT:   w_rdata = DATA_W'(w_count);
            ADDR_CONTROL: w_rdata = DATA_W'({r_irq_en, 1'b0});
            ADDR_THRESH:  w_rdata = DATA_W'(r_thresh);
            default:      w_rdata = {DATA_W{1'b0}};
         endcase
      end else begin
         w_rdata = {DATA_W{1'b0}};
      end
   end

   assign readdata = w_rdata;

endmodule
